// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the multi-channel UDP TX packetizer.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DROP,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    localparam int unsigned UDP_HDR_LEN  = 8;
    localparam int unsigned LEN_W        = 17;
    localparam logic [7:0]  DEFAULT_TTL  = 8'd64;
    localparam logic [5:0]  DEFAULT_DSCP = 6'd0;
    localparam logic [1:0]  DEFAULT_ECN  = 2'd0;

    // Count of contiguous ones in keep starting at bit 0, over the first n bits.
    function automatic logic [5:0] keep_run(input logic [31:0] keep, input int unsigned n);
        logic [5:0] cnt;
        logic       run;
        cnt = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) begin
                if (run && keep[i]) begin
                    cnt = cnt + 6'd1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/udp_tx_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module udp_tx_frame_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 184,
    parameter int unsigned AW     = 8
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read data holds between read enables so a prefetched word stays put.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/udp_tx_mux_packetizer.sv
// Round-robin AXI-S channel mux that buffers one frame, emits a UDP header
// with the exact payload length, then serialises the payload LSB-first.
module udp_tx_mux_packetizer
    import udp_tx_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned TTL         = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   s_data,
    input  logic [NUM_CH*DATA_W/8-1:0] s_keep,
    input  logic [NUM_CH-1:0]          s_valid,
    input  logic [NUM_CH-1:0]          s_last,
    output logic [NUM_CH-1:0]          s_ready,
    input  logic [31:0]                local_ip,
    input  logic [31:0]                dest_ip,
    input  logic [15:0]                local_port,
    input  logic [NUM_CH*16-1:0]       dest_port,
    output logic                       tx_udp_hdr_valid,
    input  logic                       tx_udp_hdr_ready,
    output logic [5:0]                 tx_udp_ip_dscp,
    output logic [1:0]                 tx_udp_ip_ecn,
    output logic [7:0]                 tx_udp_ip_ttl,
    output logic [31:0]                tx_udp_ip_source_ip,
    output logic [31:0]                tx_udp_ip_dest_ip,
    output logic [15:0]                tx_udp_source_port,
    output logic [15:0]                tx_udp_dest_port,
    output logic [15:0]                tx_udp_length,
    output logic [15:0]                tx_udp_checksum,
    output logic [7:0]                 tx_udp_payload_axis_tdata,
    output logic                       tx_udp_payload_axis_tvalid,
    input  logic                       tx_udp_payload_axis_tready,
    output logic                       tx_udp_payload_axis_tlast,
    output logic                       tx_udp_payload_axis_tuser,
    output logic                       frame_drop,
    output logic [$clog2(NUM_CH):0]    drop_ch,
    output logic                       busy
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned DEPTH_W = (MAX_PAYLOAD + BYTES - 1) / BYTES;
    localparam int unsigned RAM_AW  = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH_W + 1);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DROP_W  = $clog2(NUM_CH) + 1;
    localparam int unsigned BIDX_W  = $clog2(BYTES);

    localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(MAX_PAYLOAD);
    localparam logic [LEN_W-1:0]  BYTES_LEN = LEN_W'(BYTES);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH_W);
    localparam logic [BIDX_W-1:0] BIDX_MAX  = BIDX_W'(BYTES - 1);

    state_t              r_state;
    state_t              w_state_n;
    logic [CH_W-1:0]     r_grant;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [NUM_CH-1:0]   r_s_ready;
    logic [LEN_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_wr_addr;
    logic [CNT_W-1:0]    r_rd_addr;
    logic [LEN_W-1:0]    r_out_idx;
    logic [BIDX_W-1:0]   r_bidx;
    logic [DATA_W-1:0]   r_word;
    logic [7:0]          r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_hdr_valid;
    logic [31:0]         r_src_ip;
    logic [31:0]         r_dst_ip;
    logic [15:0]         r_src_port;
    logic [15:0]         r_dst_port;
    logic [15:0]         r_udp_len;
    logic [7:0]          r_ttl;
    logic                r_frame_drop;
    logic [DROP_W-1:0]   r_drop_ch;
    logic                r_busy;

    logic                w_arb_hit;
    logic [CH_W-1:0]     w_arb_idx;
    logic [CH_W-1:0]     w_rr_next;
    int unsigned         w_idx;
    logic [DATA_W-1:0]   w_data;
    logic [BYTES-1:0]    w_keep;
    logic                w_accept;
    logic                w_last;
    logic [LEN_W-1:0]    w_add;
    logic [LEN_W:0]      w_sum;
    logic [LEN_W-1:0]    w_len_next;
    logic                w_wr_en;
    logic                w_hdr_fire;
    logic                w_byte_fire;
    logic                w_load_first;
    logic                w_load_next;
    logic                w_rd_en;
    logic [CNT_W-1:0]    w_rd_addr;
    logic [DATA_W-1:0]   w_rd_q;

    // Round-robin: first valid channel at or after r_rr_ptr, wrapping.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = '0;
        w_idx     = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_arb_hit && s_valid[CH_W'(w_idx)]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = CH_W'(w_idx);
            end
        end
        w_rr_next = (w_arb_idx == CH_W'(NUM_CH - 1)) ? '0 : w_arb_idx + CH_W'(1);
    end

    // Granted-channel datapath and saturating byte count.
    always_comb begin
        w_data     = s_data[r_grant*DATA_W +: DATA_W];
        w_keep     = s_keep[r_grant*BYTES +: BYTES];
        w_last     = s_last[r_grant];
        w_accept   = s_valid[r_grant] && r_s_ready[r_grant];
        w_add      = w_last ? LEN_W'(keep_run(32'(w_keep), BYTES)) : BYTES_LEN;
        w_sum      = {1'b0, r_len} + {1'b0, w_add};
        w_len_next = w_sum[LEN_W] ? '1 : w_sum[LEN_W-1:0];
        w_wr_en    = w_accept && (r_len <= MAX_LEN) && (r_wr_addr < DEPTH_CNT);
    end

    // Next state plus payload-side read control.
    always_comb begin
        w_state_n    = r_state;
        w_hdr_fire   = r_hdr_valid && tx_udp_hdr_ready;
        w_byte_fire  = r_tvalid && tx_udp_payload_axis_tready;
        w_load_first = 1'b0;
        w_load_next  = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_addr    = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_hit) begin
                    w_state_n = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept && w_last) begin
                    w_state_n = ((w_len_next == '0) || (w_len_next > MAX_LEN)) ? ST_DROP : ST_HDR;
                end
            end
            ST_DROP: begin
                w_state_n = ST_IDLE;
            end
            ST_HDR: begin
                w_rd_en   = 1'b1;
                w_rd_addr = '0;
                if (w_hdr_fire) begin
                    w_state_n = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                w_load_first = !r_tvalid;
                w_load_next  = w_byte_fire && !r_tlast && (r_bidx == BIDX_MAX);
                w_rd_en      = (w_load_first || w_load_next) && (r_rd_addr < DEPTH_CNT);
                w_rd_addr    = r_rd_addr;
                if (w_byte_fire && r_tlast) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_s_ready    <= '0;
            r_len        <= '0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_out_idx    <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_src_ip     <= '0;
            r_dst_ip     <= '0;
            r_src_port   <= '0;
            r_dst_port   <= '0;
            r_udp_len    <= '0;
            r_ttl        <= '0;
            r_frame_drop <= 1'b0;
            r_drop_ch    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_drop <= 1'b0;
            r_busy       <= (w_state_n != ST_IDLE);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_arb_hit) begin
                        r_grant   <= w_arb_idx;
                        r_rr_ptr  <= w_rr_next;
                        r_s_ready <= NUM_CH'(1) << w_arb_idx;
                        r_len     <= '0;
                        r_wr_addr <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_len <= w_len_next;
                        if (w_wr_en) begin
                            r_wr_addr <= r_wr_addr + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_s_ready <= '0;
                            if (w_state_n == ST_DROP) begin
                                r_frame_drop <= 1'b1;
                                r_drop_ch    <= DROP_W'(r_grant);
                            end else begin
                                r_hdr_valid <= 1'b1;
                                r_src_ip    <= local_ip;
                                r_dst_ip    <= dest_ip;
                                r_src_port  <= local_port;
                                r_dst_port  <= dest_port[r_grant*16 +: 16];
                                r_udp_len   <= 16'(w_len_next) + 16'(UDP_HDR_LEN);
                                r_ttl       <= 8'(TTL);
                            end
                        end
                    end
                end
                ST_HDR: begin
                    r_rd_addr <= CNT_W'(1);
                    if (w_hdr_fire) begin
                        r_hdr_valid <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_rd_en) begin
                        r_rd_addr <= r_rd_addr + CNT_W'(1);
                    end
                    if (w_load_first) begin
                        r_tdata   <= w_rd_q[7:0];
                        r_word    <= w_rd_q >> 8;
                        r_bidx    <= '0;
                        r_out_idx <= '0;
                        r_tvalid  <= 1'b1;
                        r_tlast   <= (r_len == LEN_W'(1));
                    end else if (w_byte_fire) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                        end else begin
                            r_out_idx <= r_out_idx + LEN_W'(1);
                            r_tlast   <= ((r_out_idx + LEN_W'(2)) == r_len);
                            if (w_load_next) begin
                                r_tdata <= w_rd_q[7:0];
                                r_word  <= w_rd_q >> 8;
                                r_bidx  <= '0;
                            end else begin
                                r_tdata <= r_word[7:0];
                                r_word  <= r_word >> 8;
                                r_bidx  <= r_bidx + BIDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    udp_tx_frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_W),
        .AW     (RAM_AW)
    ) u_frame_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (RAM_AW'(r_wr_addr)),
        .i_wr_data (w_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (RAM_AW'(w_rd_addr)),
        .o_rd_data (w_rd_q)
    );

    assign s_ready                    = r_s_ready;
    assign tx_udp_hdr_valid           = r_hdr_valid;
    assign tx_udp_ip_dscp             = DEFAULT_DSCP;
    assign tx_udp_ip_ecn              = DEFAULT_ECN;
    assign tx_udp_ip_ttl              = r_ttl;
    assign tx_udp_ip_source_ip        = r_src_ip;
    assign tx_udp_ip_dest_ip          = r_dst_ip;
    assign tx_udp_source_port         = r_src_port;
    assign tx_udp_dest_port           = r_dst_port;
    assign tx_udp_length              = r_udp_len;
    assign tx_udp_checksum            = 16'd0;
    assign tx_udp_payload_axis_tdata  = r_tdata;
    assign tx_udp_payload_axis_tvalid = r_tvalid;
    assign tx_udp_payload_axis_tlast  = r_tlast;
    assign tx_udp_payload_axis_tuser  = 1'b0;
    assign frame_drop                 = r_frame_drop;
    assign drop_ch                    = r_drop_ch;
    assign busy                       = r_busy;

endmodule

// File: tb/tb_udp_tx_mux_packetizer.sv
// Directed bench for udp_tx_mux_packetizer: vector table plus hand-written corner sequences.
module tb_udp_tx_mux_packetizer;

    localparam int DATA_W = 64;
    localparam int NUM_CH = 4;
    localparam int BYTES  = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NUM_CH*DATA_W-1:0]   s_data;
    logic [NUM_CH*BYTES-1:0]    s_keep;
    logic [NUM_CH-1:0]          s_valid;
    logic [NUM_CH-1:0]          s_last;
    logic [NUM_CH-1:0]          s_ready;
    logic [31:0]                local_ip;
    logic [31:0]                dest_ip;
    logic [15:0]                local_port;
    logic [NUM_CH*16-1:0]       dest_port;
    logic                       hdr_valid;
    logic                       hdr_ready;
    logic [5:0]                 dscp;
    logic [1:0]                 ecn;
    logic [7:0]                 ttl;
    logic [31:0]                src_ip_o;
    logic [31:0]                dst_ip_o;
    logic [15:0]                src_port_o;
    logic [15:0]                dst_port_o;
    logic [15:0]                udp_len;
    logic [15:0]                udp_csum;
    logic [7:0]                 tdata;
    logic                       tvalid;
    logic                       tready;
    logic                       tlast;
    logic                       tuser;
    logic                       frame_drop;
    logic [$clog2(NUM_CH):0]    drop_ch;
    logic                       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    udp_tx_mux_packetizer #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_PAYLOAD(1472), .TTL(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .local_ip(local_ip), .dest_ip(dest_ip), .local_port(local_port), .dest_port(dest_port),
        .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready),
        .tx_udp_ip_dscp(dscp), .tx_udp_ip_ecn(ecn), .tx_udp_ip_ttl(ttl),
        .tx_udp_ip_source_ip(src_ip_o), .tx_udp_ip_dest_ip(dst_ip_o),
        .tx_udp_source_port(src_port_o), .tx_udp_dest_port(dst_port_o),
        .tx_udp_length(udp_len), .tx_udp_checksum(udp_csum),
        .tx_udp_payload_axis_tdata(tdata), .tx_udp_payload_axis_tvalid(tvalid),
        .tx_udp_payload_axis_tready(tready), .tx_udp_payload_axis_tlast(tlast),
        .tx_udp_payload_axis_tuser(tuser),
        .frame_drop(frame_drop), .drop_ch(drop_ch), .busy(busy)
    );

    typedef struct {
        int         ch;
        int         nwords;
        logic [7:0] last_keep;
        bit         exp_drop;
        int         exp_bytes;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen_byte(input int ch, input int k, input int seed);
        return 8'((seed * 31 + ch * 53 + k * 7 + (k >> 8)) & 255);
    endfunction

    function automatic logic [63:0] gen_word(input int ch, input int w, input int seed);
        logic [63:0] v;
        for (int b = 0; b < BYTES; b++) begin
            v[b*8 +: 8] = gen_byte(ch, w * BYTES + b, seed);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_valid   = '0;
        s_last    = '0;
        s_keep    = '0;
        s_data    = '0;
        hdr_ready = 1'b0;
        tready    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_frame(input int ch, input int nwords, input logic [7:0] last_keep, input int seed);
        int n;
        for (int w = 0; w < nwords; w++) begin
            s_data[ch*DATA_W +: DATA_W] = gen_word(ch, w, seed);
            s_keep[ch*BYTES +: BYTES]   = (w == nwords - 1) ? last_keep : 8'hFF;
            s_last[ch]  = (w == nwords - 1);
            s_valid[ch] = 1'b1;
            n = 0;
            while (!s_ready[ch] && n < 50) begin
                tick();
                n++;
            end
            if (!s_ready[ch]) begin
                check($sformatf("ch%0d_ready_timeout", ch), 32'(s_ready), 32'(1 << ch));
                s_valid[ch] = 1'b0;
                s_last[ch]  = 1'b0;
                return;
            end
            tick();
        end
        s_valid[ch] = 1'b0;
        s_last[ch]  = 1'b0;
    endtask

    task automatic expect_drop(input int ch, input string tag);
        bit seen     = 0;
        bit hdr_seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (hdr_valid) hdr_seen = 1;
            if (frame_drop) begin
                seen = 1;
                break;
            end
            tick();
        end
        check({tag, ".drop_pulse"}, 32'(seen), 32'd1);
        check({tag, ".drop_ch"}, 32'(drop_ch), 32'(ch));
        check({tag, ".no_hdr"}, 32'(hdr_seen), 32'd0);
        tick();
        check({tag, ".drop_one_cycle"}, 32'(frame_drop), 32'd0);
        check({tag, ".no_hdr_after"}, 32'(hdr_valid), 32'd0);
    endtask

    task automatic expect_frame(input int ch, input int nbytes, input int seed, input bit rnd_ready,
                                input int hdr_hold, input string tag);
        int n = 0;
        int unstable = 0;
        int got = 0;
        int bad = 0;
        int last_pos = -1;
        bit seen_last = 0;
        bit prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic prev_last = 1'b0;
        while (!hdr_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".hdr_valid"}, 32'(hdr_valid), 32'd1);
        if (!hdr_valid) return;
        for (int i = 0; i < hdr_hold; i++) begin
            if (!hdr_valid || udp_len !== 16'(nbytes + 8) || dst_port_o !== 16'(16'h1000 + ch)
                || src_ip_o !== local_ip || dst_ip_o !== dest_ip || tvalid) unstable++;
            tick();
        end
        check({tag, ".length"}, 32'(udp_len), 32'(nbytes + 8));
        check({tag, ".dest_port"}, 32'(dst_port_o), 32'(16'h1000 + ch));
        check({tag, ".src_port"}, 32'(src_port_o), 32'h1234);
        check({tag, ".src_ip"}, src_ip_o, 32'hC0A8_0001);
        check({tag, ".dst_ip"}, dst_ip_o, 32'hC0A8_0002);
        check({tag, ".ttl_dscp_ecn"}, {16'(ttl), 8'(dscp), 8'(ecn)}, {16'd64, 8'd0, 8'd0});
        check({tag, ".checksum"}, 32'(udp_csum), 32'd0);
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        for (int cyc = 0; cyc < 5000 && !seen_last; cyc++) begin
            if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) unstable++;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                if (tdata !== gen_byte(ch, got, seed)) bad++;
                if (tuser !== 1'b0) bad++;
                if (tlast) begin
                    seen_last = 1;
                    last_pos  = got;
                end
                got++;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            tick();
        end
        tready = 1'b0;
        check({tag, ".bad_bytes"}, 32'(bad), 32'd0);
        check({tag, ".byte_count"}, 32'(got), 32'(nbytes));
        check({tag, ".tlast_pos"}, 32'(last_pos), 32'(nbytes - 1));
        check({tag, ".stable"}, 32'(unstable), 32'd0);
        check({tag, ".tvalid_done"}, 32'(tvalid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gch;

        vecs[0] = '{0,   3, 8'h07, 1'b0,   19};
        vecs[1] = '{1, 185, 8'hFF, 1'b1,    0};
        vecs[2] = '{2,   1, 8'h00, 1'b1,    0};
        vecs[3] = '{3,   1, 8'hFF, 1'b0,    8};
        vecs[4] = '{1, 184, 8'hFF, 1'b0, 1472};
        vecs[5] = '{0,   2, 8'h01, 1'b0,    9};
        vecs[6] = '{2,   1, 8'h0B, 1'b0,    2};

        local_ip   = 32'hC0A8_0001;
        dest_ip    = 32'hC0A8_0002;
        local_port = 16'h1234;
        for (int c = 0; c < NUM_CH; c++) dest_port[c*16 +: 16] = 16'(16'h1000 + c);

        do_reset();
        check("rst.s_ready", 32'(s_ready), 32'd0);
        check("rst.hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst.tvalid_tlast", {30'd0, tvalid, tlast}, 32'd0);
        check("rst.length", 32'(udp_len), 32'd0);
        check("rst.ttl", 32'(ttl), 32'd0);
        check("rst.drop", {28'd0, frame_drop, drop_ch}, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);

        // All four channels valid with one-word frames: strict round robin from ch0.
        for (int c = 0; c < NUM_CH; c++) begin
            s_data[c*DATA_W +: DATA_W] = gen_word(c, 0, 50);
            s_keep[c*BYTES +: BYTES]   = 8'hFF;
        end
        s_last  = '1;
        s_valid = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            n = 0;
            while (s_ready == '0 && n < 50) begin
                tick();
                n++;
            end
            gch = -1;
            for (int c = 0; c < NUM_CH; c++) if (s_ready[c]) gch = c;
            check($sformatf("rr.grant%0d", i), 32'(gch), 32'(i));
            check($sformatf("rr.onehot%0d", i), 32'($countones(s_ready)), 32'd1);
            tick();
            if (gch >= 0) s_valid[gch] = 1'b0;
            expect_frame(i, 8, 50, 1'b0, 0, $sformatf("rr%0d", i));
        end
        s_valid = '0;
        s_last  = '0;

        for (int i = 0; i < 7; i++) begin
            drive_frame(vecs[i].ch, vecs[i].nwords, vecs[i].last_keep, i + 1);
            if (vecs[i].exp_drop) expect_drop(vecs[i].ch, $sformatf("v%0d", i));
            else expect_frame(vecs[i].ch, vecs[i].exp_bytes, i + 1, 1'b0, 0, $sformatf("v%0d", i));
        end
        check("drop_ch_held", 32'(drop_ch), 32'd2);

        // Header back-pressure then random payload back-pressure.
        drive_frame(3, 2, 8'h3F, 77);
        expect_frame(3, 14, 77, 1'b1, 10, "bp");

        // Reset in the middle of a payload, then ch0 must win over ch2.
        drive_frame(0, 4, 8'hFF, 90);
        n = 0;
        while (!hdr_valid && n < 50) begin
            tick();
            n++;
        end
        hdr_ready = 1'b1;
        tick();
        hdr_ready = 1'b0;
        tready = 1'b1;
        repeat (6) tick();
        check("mid.busy", 32'(busy), 32'd1);
        check("mid.tvalid", 32'(tvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst.tvalid_tlast", {30'd0, tvalid, tlast}, 32'd0);
        check("midrst.tdata", 32'(tdata), 32'd0);
        check("midrst.hdr", {31'd0, hdr_valid}, 32'd0);
        check("midrst.busy_ready", {27'd0, busy, s_ready}, 32'd0);
        check("midrst.length", 32'(udp_len), 32'd0);
        tready = 1'b0;
        rst_n  = 1'b1;
        tick();
        s_data[2*DATA_W +: DATA_W] = gen_word(2, 0, 60);
        s_data[0*DATA_W +: DATA_W] = gen_word(0, 0, 61);
        s_keep = '1;
        s_last = 4'b0101;
        s_valid = 4'b0101;
        n = 0;
        while (s_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        check("post_rst.grant_ch0", 32'(s_ready), 32'h1);
        tick();
        s_valid[0] = 1'b0;
        expect_frame(0, 8, 61, 1'b0, 0, "post_rst0");
        n = 0;
        while (s_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        check("post_rst.grant_ch2", 32'(s_ready), 32'h4);
        tick();
        s_valid[2] = 1'b0;
        s_last     = '0;
        expect_frame(2, 8, 60, 1'b0, 0, "post_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
